// File: rtl/jt51_wrarb.sv
// jt51_wrarb: round-robin arbiter for two register-write requesters in front of the jt51 CPU port.
// Sequences the address/data strobes, then polls the busy flag before accepting the next write.
module jt51_wrarb #(
   parameter int WR_HOLD  = 2,
   parameter int BUSY_DLY = 2,
   parameter int TMO      = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       req0_valid,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   input  logic [7:0] dout,
   output logic       cs_n,
   output logic       wr_n,
   output logic       a0,
   output logic [7:0] din,
   output logic       active,
   output logic       grant,
   output logic       timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADR   = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_DAT   = 3'd3;
   localparam logic [2:0] S_WAITD = 3'd4;
   localparam logic [2:0] S_POLL  = 3'd5;

   localparam logic [7:0] HOLD_LAST = 8'(WR_HOLD - 1);
   localparam logic [7:0] DLY_LAST  = 8'(BUSY_DLY - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TMO - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] din_q, din_d;
   logic       cs_n_q, cs_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a0_q, a0_d;
   logic       grant_q, grant_d;
   logic       rdy0_q, rdy0_d;
   logic       rdy1_q, rdy1_d;
   logic       tmo_q, tmo_d;

   logic       pick0_s, pick1_s;
   logic [7:0] acc_addr_s, acc_data_s;
   logic       busy_s;
   logic       unused_s;

   // On contention the requester that did not own the last transaction wins.
   assign pick0_s    = req0_valid & (~req1_valid | grant_q);
   assign pick1_s    = req1_valid & (~req0_valid | ~grant_q);
   assign acc_addr_s = pick1_s ? req1_addr : req0_addr;
   assign acc_data_s = pick1_s ? req1_data : req0_data;
   assign busy_s     = dout[7];
   assign unused_s   = ^dout[6:0];

   // Next-state and next-output computation for the write sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      din_d   = din_q;
      cs_n_d  = cs_n_q;
      wr_n_d  = wr_n_q;
      a0_d    = a0_q;
      grant_d = grant_q;
      rdy0_d  = 1'b0;
      rdy1_d  = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick0_s || pick1_s) begin
               state_d = S_ADR;
               cnt_d   = 8'd0;
               grant_d = pick1_s;
               rdy0_d  = pick0_s;
               rdy1_d  = pick1_s;
               addr_d  = acc_addr_s;
               data_d  = acc_data_s;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               a0_d    = 1'b0;
               din_d   = acc_addr_s;
            end else begin
               cs_n_d = 1'b1;
               wr_n_d = 1'b1;
            end
         end
         S_ADR: begin
            if (cen && cnt_q == HOLD_LAST) begin
               state_d = S_GAP;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b1;
               wr_n_d  = 1'b1;
            end else if (cen) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_GAP: begin
            if (cen) begin
               state_d = S_DAT;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               a0_d    = 1'b1;
               din_d   = data_q;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_DAT: begin
            if (cen && cnt_q == HOLD_LAST) begin
               state_d = S_WAITD;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               a0_d    = 1'b0;
            end else if (cen) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_WAITD: begin
            // Give the chip time to raise busy before the first status read.
            if (cen && cnt_q == DLY_LAST) begin
               state_d = S_POLL;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b0;
            end else if (cen) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_POLL: begin
            if (cen && !busy_s) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b1;
            end else if (cen && cnt_q == TMO_LAST) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
               cs_n_d  = 1'b1;
               tmo_d   = 1'b1;
            end else if (cen) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            a0_d    = 1'b0;
         end
      endcase
   end

   // State, counter and registered bus/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 8'd0;
         data_q  <= 8'd0;
         din_q   <= 8'd0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         a0_q    <= 1'b0;
         grant_q <= 1'b1;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         din_q   <= din_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         a0_q    <= a0_d;
         grant_q <= grant_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         tmo_q   <= tmo_d;
      end
   end

   assign req0_ready = rdy0_q;
   assign req1_ready = rdy1_q;
   assign cs_n       = cs_n_q;
   assign wr_n       = wr_n_q;
   assign a0         = a0_q;
   assign din        = din_q;
   assign active     = (state_q != S_IDLE);
   assign grant      = grant_q;
   assign timeout    = tmo_q;

endmodule

// File: tb/tb_jt51_wrarb.sv
// Directed bench for jt51_wrarb: default-parameter instance plus a TMO=4 instance for the timeout case.
module tb_jt51_wrarb;

   localparam int WH = 2;
   localparam int BD = 2;

   logic       clk, rst, cen, cen_run, sel_tmo;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_addr, req0_data, req1_addr, req1_data, dout;

   logic       p_rdy0, p_rdy1, p_cs, p_wr, p_a0, p_act, p_grant, p_tmo;
   logic [7:0] p_din;
   logic       t_rdy0, t_rdy1, t_cs, t_wr, t_a0, t_act, t_grant, t_tmo;
   logic [7:0] t_din;

   logic       s_rdy0, s_rdy1, s_cs, s_wr, s_a0, s_act, s_grant, s_tmo;
   logic [7:0] s_din;

   int n_checks = 0;
   int n_errors = 0;
   int rdy0_cnt = 0;
   int tmo_cnt  = 0;

   logic [10:0] tr[$];
   logic [10:0] ex[$];

   logic [7:0] d0_tab [3] = '{8'h11, 8'h12, 8'h13};
   logic [7:0] d1_tab [3] = '{8'h21, 8'h22, 8'h23};

   jt51_wrarb #(.WR_HOLD(WH), .BUSY_DLY(BD), .TMO(255)) u_dut (
      .clk(clk), .rst(rst), .cen(cen),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(p_rdy0),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(p_rdy1),
      .dout(dout), .cs_n(p_cs), .wr_n(p_wr), .a0(p_a0), .din(p_din),
      .active(p_act), .grant(p_grant), .timeout(p_tmo)
   );

   jt51_wrarb #(.WR_HOLD(WH), .BUSY_DLY(BD), .TMO(4)) u_tmo (
      .clk(clk), .rst(rst), .cen(cen),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(t_rdy0),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(t_rdy1),
      .dout(dout), .cs_n(t_cs), .wr_n(t_wr), .a0(t_a0), .din(t_din),
      .active(t_act), .grant(t_grant), .timeout(t_tmo)
   );

   assign s_rdy0  = sel_tmo ? t_rdy0  : p_rdy0;
   assign s_rdy1  = sel_tmo ? t_rdy1  : p_rdy1;
   assign s_cs    = sel_tmo ? t_cs    : p_cs;
   assign s_wr    = sel_tmo ? t_wr    : p_wr;
   assign s_a0    = sel_tmo ? t_a0    : p_a0;
   assign s_din   = sel_tmo ? t_din   : p_din;
   assign s_act   = sel_tmo ? t_act   : p_act;
   assign s_grant = sel_tmo ? t_grant : p_grant;
   assign s_tmo   = sel_tmo ? t_tmo   : p_tmo;

   always #5 clk = ~clk;

   // cen is high on every other rising edge unless the bench stalls it.
   always @(negedge clk) cen = cen_run ? ~cen : 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      dout = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Expected per-cen-tick {cs_n, wr_n, a0, din} from acceptance to the end of polling.
   task automatic build_exp(input logic [7:0] a, input logic [7:0] d, input int npoll);
      ex.delete();
      for (int i = 0; i < WH; i++) ex.push_back({3'b000, a});
      ex.push_back({3'b110, a});
      for (int i = 0; i < WH; i++) ex.push_back({3'b001, d});
      for (int i = 0; i < BD; i++) ex.push_back({3'b110, d});
      for (int i = 0; i < npoll; i++) ex.push_back({3'b010, d});
   endtask

   task automatic cmp_trace(input string tag);
      check({tag, "_len"}, 32'(tr.size()), 32'(ex.size()));
      for (int i = 0; i < tr.size() && i < ex.size(); i++) check(tag, 32'(tr[i]), 32'(ex[i]));
   endtask

   // Waits for an acceptance, records one sample per cen tick until active drops.
   task automatic run_txn(input int busy_n, input int stall_at, input logic [7:0] frz_din,
                          output int who, output int npoll, output logic tmo);
      logic done;
      who = -1; npoll = 0; tmo = 1'b0; done = 1'b0;
      tr.delete();
      for (int k = 0; k < 4000 && !done; k++) begin
         @(negedge clk); #1;
         if (s_rdy0) rdy0_cnt++;
         if (s_tmo) tmo_cnt++;
         if (who < 0) begin
            if (s_rdy0 || s_rdy1) begin
               check("ready_excl", 32'(s_rdy0 & s_rdy1), 32'd0);
               who = s_rdy0 ? 0 : 1;
            end
         end else if (!s_act) begin
            tmo = s_tmo;
            done = 1'b1;
         end
         if (who >= 0 && !done && cen) begin
            tr.push_back({s_cs, s_wr, s_a0, s_din});
            if (!s_cs && s_wr) begin
               npoll++;
               dout = (npoll <= busy_n) ? 8'h80 : 8'h00;
            end
            if (tr.size() == stall_at) begin
               cen_run = 1'b0;
               for (int j = 0; j < 20; j++) begin
                  @(negedge clk); #1;
                  check("stall_freeze", 32'({s_cs, s_wr, s_a0, s_din, s_act}), 32'({3'b000, frz_din, 1'b1}));
               end
               cen_run = 1'b1;
            end
         end
      end
      if (!done) check("txn_bound", 32'd0, 32'd1);
   endtask

   initial begin
      int who, np;
      logic tm, found;
      int i0, i1;
      clk = 1'b0; cen = 1'b0; cen_run = 1'b1; sel_tmo = 1'b0;
      rst = 1'b1; dout = 8'h00;
      req0_valid = 1'b0; req0_addr = 8'h00; req0_data = 8'h00;
      req1_valid = 1'b0; req1_addr = 8'h00; req1_data = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_bus", 32'({p_cs, p_wr, p_a0, p_din}), 32'({3'b110, 8'h00}));
      check("rst_ready", 32'({p_rdy0, p_rdy1}), 32'd0);
      check("rst_status", 32'({p_act, p_grant, p_tmo}), 32'(3'b010));
      rst = 1'b0;

      // Single write, busy already clear
      do_reset();
      rdy0_cnt = 0;
      req0_valid = 1'b1; req0_addr = 8'h20; req0_data = 8'hC7;
      run_txn(0, -1, 8'h00, who, np, tm);
      req0_valid = 1'b0;
      check("single_who", 32'(who), 32'd0);
      check("single_ready_width", 32'(rdy0_cnt), 32'd1);
      check("single_polls", 32'(np), 32'd1);
      check("single_tmo", 32'(tm), 32'd0);
      check("single_grant", 32'(s_grant), 32'd0);
      build_exp(8'h20, 8'hC7, 1);
      cmp_trace("single_trace");

      // Busy for 5 samples then clear
      do_reset();
      req0_valid = 1'b1; req0_addr = 8'h20; req0_data = 8'hC7;
      run_txn(5, -1, 8'h00, who, np, tm);
      req0_valid = 1'b0;
      check("busy_polls", 32'(np), 32'd6);
      check("busy_tmo", 32'(tm), 32'd0);
      build_exp(8'h20, 8'hC7, 6);
      cmp_trace("busy_trace");

      // cen stalled for 20 clk after the first ADR tick
      do_reset();
      req0_valid = 1'b1; req0_addr = 8'h5A; req0_data = 8'h3C;
      run_txn(0, 1, 8'h5A, who, np, tm);
      req0_valid = 1'b0;
      build_exp(8'h5A, 8'h3C, 1);
      cmp_trace("stall_trace");

      // Contention: both requesters with three writes each
      do_reset();
      i0 = 0; i1 = 0;
      req0_valid = 1'b1; req0_addr = 8'h08; req0_data = d0_tab[0];
      req1_valid = 1'b1; req1_addr = 8'h10; req1_data = d1_tab[0];
      for (int t = 0; t < 6; t++) begin
         run_txn(0, -1, 8'h00, who, np, tm);
         check("cont_who", 32'(who), 32'(t % 2));
         check("cont_grant", 32'(s_grant), 32'(t % 2));
         if (who == 0 && i0 < 3) begin
            build_exp(8'h08, d0_tab[i0], 1);
            cmp_trace("cont_trace0");
            i0++;
            if (i0 < 3) req0_data = d0_tab[i0];
            else req0_valid = 1'b0;
         end else if (who == 1 && i1 < 3) begin
            build_exp(8'h10, d1_tab[i1], 1);
            cmp_trace("cont_trace1");
            i1++;
            if (i1 < 3) req1_data = d1_tab[i1];
            else req1_valid = 1'b0;
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Timeout with TMO=4, then the pending req1 is accepted
      sel_tmo = 1'b1;
      do_reset();
      tmo_cnt = 0;
      req0_valid = 1'b1; req0_addr = 8'h28; req0_data = 8'h11;
      req1_valid = 1'b1; req1_addr = 8'h30; req1_data = 8'h22;
      run_txn(1000, -1, 8'h00, who, np, tm);
      req0_valid = 1'b0;
      check("tmo_who", 32'(who), 32'd0);
      check("tmo_polls", 32'(np), 32'd4);
      check("tmo_flag", 32'(tm), 32'd1);
      build_exp(8'h28, 8'h11, 4);
      cmp_trace("tmo_trace");
      dout = 8'h00;
      run_txn(0, -1, 8'h00, who, np, tm);
      req1_valid = 1'b0;
      check("tmo_next_who", 32'(who), 32'd1);
      check("tmo_next_flag", 32'(tm), 32'd0);
      check("tmo_pulses", 32'(tmo_cnt), 32'd1);
      build_exp(8'h30, 8'h22, 1);
      cmp_trace("tmo_next_trace");
      sel_tmo = 1'b0;

      // Asynchronous reset during the data strobe
      do_reset();
      req0_valid = 1'b1; req0_addr = 8'h40; req0_data = 8'h55;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk); #1;
         if (!s_cs && s_a0) found = 1'b1;
      end
      check("dat_reached", 32'(found), 32'd1);
      check("dat_grant", 32'(s_grant), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_async_bus", 32'({s_cs, s_wr, s_din}), 32'({2'b11, 8'h00}));
      check("rst_async_status", 32'({s_act, s_grant}), 32'(2'b01));
      req1_valid = 1'b1; req1_addr = 8'h50; req1_data = 8'h66;
      @(negedge clk);
      rst = 1'b0;
      run_txn(0, -1, 8'h00, who, np, tm);
      check("rst_next_who", 32'(who), 32'd0);
      build_exp(8'h40, 8'h55, 1);
      cmp_trace("rst_next_trace");
      req0_valid = 1'b0; req1_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
